pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_HOLD_CYCLES, default 16: cycles PLL RESET_N is held low per attempt; legal range 1..65535.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 4800: cycles allowed for synchronized lock to assert after PLL reset release; legal range 1..65535.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 480: consecutive synchronized-lock-high cycles required before system reset release; legal range 1..65535.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: lock-timeout attempts tolerated before fault; legal range 1..15.
REQ-005 SHALL have port clk  input  1  free-running reference clock (HSOSC domain, never the PLL output).
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port pll_locked  input  1  raw PLL LOCK, asynchronous to clk.
REQ-008 SHALL have port relock_req  input  1  single-cycle request to restart the sequence.
REQ-009 SHALL have port pll_rst_n  output  1  drives PLL RESET_N.
REQ-010 SHALL have port sys_rst_n  output  1  active-low system reset, high only in RUN.
REQ-011 SHALL have port pll_fault  output  1  sticky; retries exhausted.
REQ-012 SHALL have port retry_count  output  4  timeouts in current sequence.
REQ-013 SHALL have port state  output  3  debug state code: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.

Function
REQ-014 SHALL pass pll_locked through a 2-flop synchronizer; all decisions use the synchronized value (lock_s), 2-cycle latency.
REQ-015 SHALL use one 16-bit down/up cycle counter, cleared on every state transition.
REQ-016 SHALL register all outputs; outputs change only on clk edges.
REQ-017 RESET: pll_rst_n=0, sys_rst_n=0; after exactly RST_HOLD_CYCLES cycles in RESET, go to WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst_n=1, sys_rst_n=0; lock_s=1 -> STABLE; counter reaching LOCK_TIMEOUT_CYCLES with lock_s=0 -> retry_count+1 then RESET, or FAULT if incremented value equals MAX_RETRIES.
REQ-019 STABLE: pll_rst_n=1, sys_rst_n=0; lock_s=0 -> WAIT_LOCK (timeout restarts, no retry increment); LOCK_STABLE_CYCLES consecutive lock_s=1 cycles -> RUN.
REQ-020 RUN: pll_rst_n=1, sys_rst_n=1; lock_s=0 -> RESET, retry_count cleared to 0, sys_rst_n low on the same edge the state leaves RUN.
REQ-021 FAULT: pll_rst_n=0, sys_rst_n=0, pll_fault=1; remains until relock_req or rst_n.
REQ-022 relock_req in any state SHALL force RESET on the next edge, clear retry_count and pll_fault; it takes priority over every other transition that cycle.
REQ-023 Lock-loss in RUN coincident with relock_req SHALL yield one RESET entry, retry_count=0.
REQ-024 retry_count SHALL saturate at MAX_RETRIES, never wrap.
REQ-025 Undefined state encodings SHALL recover to RESET next cycle.

Reset
REQ-026 rst_n low SHALL immediately force state=RESET, pll_rst_n=0, sys_rst_n=0, pll_fault=0, retry_count=0, counter=0, synchronizer flops=0.
REQ-027 rst_n asserted mid-sequence (any state) SHALL abort it; after release the full sequence restarts from RESET with RST_HOLD_CYCLES.
REQ-028 pll_rst_n SHALL never be driven from pll_locked combinationally.

Verification (RST_HOLD=4, LOCK_TIMEOUT=100, LOCK_STABLE=8, MAX_RETRIES=3)
REQ-029 Nominal: release rst_n, pll_locked high 20 cycles after pll_rst_n rises -> pll_rst_n low 4 cycles, sys_rst_n rises 2+8(+1) cycles after lock, state=3, retry_count=0.
REQ-030 Timeout/fault: pll_locked held low -> three RESET/WAIT_LOCK attempts of 4+100 cycles, retry_count 1,2 then FAULT with pll_fault=1, retry_count=3, pll_rst_n=0.
REQ-031 Glitchy lock: lock high 5 cycles, low 1, high 8 -> STABLE->WAIT_LOCK->STABLE->RUN, no retry increment, sys_rst_n stays low until 8 clean cycles.
REQ-032 Lock loss in RUN: drop pll_locked -> after 2-cycle sync, sys_rst_n=0 and state=0 same edge, retry_count=0, sequence re-runs.
REQ-033 relock_req: pulse in FAULT -> next edge state=0, pll_fault=0, retry_count=0; pulse in RUN coincident with lock loss -> single RESET entry.
REQ-034 Async reset mid-STABLE: assert rst_n low between edges -> outputs at reset values immediately, restart from RESET after release.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: holds PLL reset, waits for a synchronized lock with timeout/retry,
// requires a stable lock window, then releases system reset; lock loss or relock restarts it.
module pll_reset_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 4800,
  parameter int unsigned LOCK_STABLE_CYCLES  = 480,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst_n,
  output logic       sys_rst_n,
  output logic       pll_fault,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  // Terminal counts: the counter starts at 0 on state entry, so "N cycles" ends at N-1.
  localparam logic [15:0] HOLD_LAST    = 16'(RST_HOLD_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRIES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic [3:0]  retry_inc;
  logic        lock_meta_q, lock_s_q;
  logic        pll_rst_n_q, sys_rst_n_q, pll_fault_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  assign retry_inc = (retry_q >= RETRY_MAX) ? RETRY_MAX : retry_q + 4'd1;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    case (state_q)
      ST_RESET: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        cnt_d = cnt_q + 16'd1;
        if (lock_s_q) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_RESET;
        end
      end
      ST_STABLE: begin
        cnt_d = cnt_q + 16'd1;
        if (!lock_s_q)                  state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST)  state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          state_d = ST_RESET;
          retry_d = '0;
        end
      end
      ST_FAULT: ;
      default: state_d = ST_RESET;
    endcase

    // Relock overrides everything and restarts the hold window even from RESET.
    if (relock_req) begin
      state_d = ST_RESET;
      retry_d = '0;
    end

    if (state_d != state_q || relock_req) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_n_q <= 1'b0;
      sys_rst_n_q <= 1'b0;
      pll_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_n_q <= !(state_d == ST_RESET || state_d == ST_FAULT);
      sys_rst_n_q <= (state_d == ST_RUN);
      pll_fault_q <= (state_d == ST_FAULT);
    end
  end

  assign pll_rst_n   = pll_rst_n_q;
  assign sys_rst_n   = sys_rst_n_q;
  assign pll_fault   = pll_fault_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with RST_HOLD=4, LOCK_TIMEOUT=100, LOCK_STABLE=8,
// MAX_RETRIES=3; inputs change #1 after posedge (or at negedge), outputs sampled at negedge.
module tb_pll_reset_sequencer;

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst_n, sys_rst_n, pll_fault;
  logic [3:0] retry_count;
  logic [2:0] state;
  logic [9:0] obs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES(100),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst_n  (pll_rst_n),
    .sys_rst_n  (sys_rst_n),
    .pll_fault  (pll_fault),
    .retry_count(retry_count),
    .state      (state)
  );

  assign obs = {state, pll_rst_n, sys_rst_n, pll_fault, retry_count};

  // Output pattern implied by a state code and retry count.
  function automatic logic [9:0] exp_out(input logic [2:0] st, input logic [3:0] rc);
    logic prn, srn, flt;
    prn = (st == S_WAIT) || (st == S_STABLE) || (st == S_RUN);
    srn = (st == S_RUN);
    flt = (st == S_FAULT);
    return {st, prn, srn, flt, rc};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; pll_locked = 1'b0; relock_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (obs !== exp_out(S_RESET, 4'd0)) begin
      miscompares++;
      $display("FAIL reset_hold: got %b want %b (st|prn|srn|flt|rc)", obs, exp_out(S_RESET, 4'd0));
    end
    pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (obs !== exp_out(S_RESET, 4'd0)) begin
      miscompares++;
      $display("FAIL reset_ignores_lock: got %b want %b", obs, exp_out(S_RESET, 4'd0));
    end
    pll_locked = 1'b0;
  endtask

  task automatic test_nominal;
    int k_rise = -1;
    int k_stable = -1;
    int k_run = -1;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); @(negedge clk);
      if (pll_rst_n) begin k_rise = k; break; end
    end
    vectors++;
    if (k_rise !== 4) begin
      miscompares++;
      $display("FAIL nominal_pll_rst_low: got %0d cycles want 4", k_rise);
    end
    repeat (20) @(posedge clk);
    #1 pll_locked = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (state == S_STABLE && k_stable < 0) k_stable = k;
      if (state == S_RUN) begin k_run = k; break; end
    end
    vectors++;
    if (k_stable !== 3 || k_run !== 11) begin
      miscompares++;
      $display("FAIL nominal_timing: got stable@%0d run@%0d want stable@3 run@11", k_stable, k_run);
    end
    vectors++;
    if (obs !== exp_out(S_RUN, 4'd0)) begin
      miscompares++;
      $display("FAIL nominal_run: got %b want %b", obs, exp_out(S_RUN, 4'd0));
    end
  endtask

  task automatic test_lock_loss_in_run;
    int k_drop = -1;
    int k_run = -1;
    logic [9:0] at_drop = 'x;
    @(posedge clk); #1 pll_locked = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); @(negedge clk);
      if (!sys_rst_n) begin k_drop = k; at_drop = obs; break; end
    end
    vectors++;
    if (k_drop !== 3 || at_drop !== exp_out(S_RESET, 4'd0)) begin
      miscompares++;
      $display("FAIL lockloss_drop: got edge %0d obs %b want edge 3 obs %b",
               k_drop, at_drop, exp_out(S_RESET, 4'd0));
    end
    pll_locked = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); @(negedge clk);
      if (state == S_RUN) begin k_run = k; break; end
    end
    vectors++;
    if (k_run !== 13 || obs !== exp_out(S_RUN, 4'd0)) begin
      miscompares++;
      $display("FAIL lockloss_rerun: got run@%0d obs %b want run@13 obs %b",
               k_run, obs, exp_out(S_RUN, 4'd0));
    end
  endtask

  task automatic test_relock_with_lock_loss;
    int k_wait = -1;
    @(posedge clk); #1 pll_locked = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 relock_req = 1'b1;
    @(posedge clk); #1 relock_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs !== exp_out(S_RESET, 4'd0)) begin
      miscompares++;
      $display("FAIL coincident_entry: got %b want %b", obs, exp_out(S_RESET, 4'd0));
    end
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (state != S_RESET) begin k_wait = k; break; end
    end
    vectors++;
    if (k_wait !== 4 || obs !== exp_out(S_WAIT, 4'd0)) begin
      miscompares++;
      $display("FAIL coincident_single_reset: got leave@%0d obs %b want leave@4 obs %b",
               k_wait, obs, exp_out(S_WAIT, 4'd0));
    end
  endtask

  task automatic test_glitchy_lock;
    logic [2:0] exp_st [17];
    exp_st = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd2,
               3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
    @(posedge clk); #1 pll_locked = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      @(posedge clk);
      if (j == 5) #1 pll_locked = 1'b0;
      if (j == 6) #1 pll_locked = 1'b1;
      @(negedge clk);
      vectors++;
      if (obs !== exp_out(exp_st[j-1], 4'd0)) begin
        miscompares++;
        $display("FAIL glitch_trace edge %0d: got %b want %b", j, obs, exp_out(exp_st[j-1], 4'd0));
      end
    end
  endtask

  typedef struct {
    int         k;
    logic [2:0] st;
    logic [3:0] rc;
  } point_t;

  task automatic test_timeout_fault;
    point_t pts [14];
    pts = '{'{2,   S_RUN,    4'd0}, '{3,   S_RESET,  4'd0}, '{6,   S_RESET,  4'd0},
            '{7,   S_WAIT,   4'd0}, '{106, S_WAIT,   4'd0}, '{107, S_RESET,  4'd1},
            '{110, S_RESET,  4'd1}, '{111, S_WAIT,   4'd1}, '{210, S_WAIT,   4'd1},
            '{211, S_RESET,  4'd2}, '{215, S_WAIT,   4'd2}, '{314, S_WAIT,   4'd2},
            '{315, S_FAULT,  4'd3}, '{330, S_FAULT,  4'd3}};
    @(posedge clk); #1 pll_locked = 1'b0;
    for (int k = 1; k <= 330; k++) begin
      @(posedge clk); @(negedge clk);
      foreach (pts[i]) begin
        if (pts[i].k == k) begin
          vectors++;
          if (obs !== exp_out(pts[i].st, pts[i].rc)) begin
            miscompares++;
            $display("FAIL timeout_trace edge %0d: got %b want %b",
                     k, obs, exp_out(pts[i].st, pts[i].rc));
          end
        end
      end
    end
  endtask

  task automatic test_relock_in_fault;
    @(posedge clk); #1 relock_req = 1'b1;
    @(posedge clk); #1 relock_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs !== exp_out(S_RESET, 4'd0)) begin
      miscompares++;
      $display("FAIL relock_from_fault: got %b want %b", obs, exp_out(S_RESET, 4'd0));
    end
  endtask

  task automatic test_async_reset_mid_stable;
    int k_st = -1;
    int k_rise = -1;
    int k_run = -1;
    pll_locked = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); @(negedge clk);
      if (state == S_STABLE) begin k_st = k; break; end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (k_st !== 5 || obs !== exp_out(S_STABLE, 4'd0)) begin
      miscompares++;
      $display("FAIL async_pre_stable: got stable@%0d obs %b want stable@5 obs %b",
               k_st, obs, exp_out(S_STABLE, 4'd0));
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== exp_out(S_RESET, 4'd0)) begin
      miscompares++;
      $display("FAIL async_immediate: got %b want %b", obs, exp_out(S_RESET, 4'd0));
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); @(negedge clk);
      if (pll_rst_n && k_rise < 0) k_rise = k;
      if (state == S_RUN) begin k_run = k; break; end
    end
    vectors++;
    if (k_rise !== 4 || k_run !== 13) begin
      miscompares++;
      $display("FAIL async_restart: got rise@%0d run@%0d want rise@4 run@13", k_rise, k_run);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss_in_run();
    test_relock_with_lock_loss();
    test_glitchy_lock();
    test_timeout_fault();
    test_relock_in_fault();
    test_async_reset_mid_stable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
